lt_int_serial_ctrl: RTL and testbench
=====================================

// Module: lt_int_serial_ctrl
// PURPOSE
//  Sequencer for a chunked (multi-cycle) 32-bit signed less-than compare.
//  - Captures A/B on a valid/ready handshake.
//  - Walks the operands LSB-chunk first through a CHUNK-bit borrow-subtract slice,
//    carrying the borrow in a register; resolves the sign on the final chunk.
//  - Trades latency for a WIDTH/CHUNK-times smaller compare datapath in PIM-style
//    bit-serial flows.
// PARAMETERS
//  WIDTH      32  operand width; signed two's complement
//  CHUNK      8   bits processed per cycle; WIDTH % CHUNK == 0 required (elaboration $error otherwise)
//  IMPL_TYPE  0   forwarded to the per-chunk subtract/compare slice implementation
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  A          in   WIDTH  signed operand A
//  B          in   WIDTH  signed operand B
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  Y          out  1      1 when A < B (signed)
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset values (async on rst):
//  - state = IDLE; in_ready = 1; out_valid = 0; Y = 0; busy = 0.
//  - Borrow register, chunk counter and operand shift registers all cleared.
//  States:
//  - IDLE -> RUN on in_valid && in_ready; A and B are latched into shift registers.
//  - RUN, each cycle:
//    - {bo, d} = a_chunk - b_chunk - borrow, using the low CHUNK bits of the shift registers.
//    - borrow <= bo; both shift registers shift right by CHUNK; counter increments.
//  - Last chunk (counter == NCHUNK-1, NCHUNK = WIDTH/CHUNK):
//    - Y <= bo ^ A[WIDTH-1] ^ B[WIDTH-1], using the latched sign bits.
//    - Transition to DONE.
//  - DONE: out_valid = 1 and Y held stable. On out_ready -> IDLE: out_valid drops
//    the next cycle and in_ready rises that same cycle.
//  Latency: the acceptance edge is cycle 0; out_valid is high from cycle NCHUNK onward.
//    WIDTH=32/CHUNK=8 -> 4 cycles. CHUNK == WIDTH -> 1 cycle.
//  Throughput: at most one compare per NCHUNK+1 cycles. No back-to-back accept in the
//    cycle that DONE is acknowledged.
//  in_valid outside IDLE is ignored; A/B may change freely after the acceptance edge.
//  out_ready outside DONE is ignored. Y is don't-care-free: it holds its last value
//    until the next result.
//  Arithmetic:
//  - Chunk subtract is CHUNK+1 bits wide; bo is the MSB of the result.
//  - Borrow starts at 0 for every new operation.
//  - Counter width is $clog2(NCHUNK)+1 and must not wrap within one operation.
//  Boundary values:
//  - A == B -> Y = 0.
//  - Most-negative vs most-positive -> Y = 1.
//  - Operands differing only in the low chunk resolve through the borrow chain.
//  Reset mid-RUN or mid-DONE:
//  - Aborts immediately; no out_valid is produced for the aborted operation.
// CONFIGURATION
//  LT_INT_SERIAL_EQ_FLAG_EN defined:
//  - Adds output port EQ (1 bit).
//  - Register nz <= nz | (|d) each RUN cycle; nz clears on acceptance.
//  - EQ = ~nz, valid with out_valid.
//  - Reset value of EQ is 0.
//  Not defined: no EQ port, no nz register; behaviour is otherwise identical.
// TESTING
//  - Reset then idle: in_ready=1, out_valid=0, busy=0, Y=0 for 5 cycles with no stimulus.
//  - A=-5, B=3, out_ready=1: out_valid high exactly 4 cycles after accept, Y=1; next A=3, B=-5 -> Y=0.
//  - A=32'h8000_0000, B=32'h7FFF_FFFF -> Y=1; A=B=32'h1234_5678 -> Y=0 (EQ=1 with the macro).
//  - A=32'h0000_0100, B=32'h0000_01FF (low-chunk borrow) -> Y=1; swapped operands -> Y=0.
//  - Backpressure: out_ready=0 for 6 cycles -> out_valid and Y stable, in_ready=0,
//    new in_valid ignored; out_ready=1 -> IDLE next cycle.
//  - Assert rst in the 2nd RUN cycle -> all outputs at reset values asynchronously;
//    a fresh A=1, B=2 then completes with Y=1.

Source files
------------

// File: rtl/lt_int_serial_ctrl.sv
// lt_int_serial_ctrl: chunked signed less-than compare sequencer.
// Operands are captured on a valid/ready handshake and walked LSB chunk
// first through a CHUNK-bit borrow-subtract slice. The borrow is carried
// between chunks in a register. The sign correction is applied on the
// last chunk using the captured operand sign bits.
// Optional feature macro: LT_INT_SERIAL_EQ_FLAG_EN adds an EQ output that
// reports A == B alongside the result.

// Per-chunk subtract slice: {bo, d} = a - b - bin, CHUNK+1 bits wide.
// IMPL_TYPE 0 uses a plain arithmetic subtract; any other value uses an
// explicit bitwise ripple-borrow chain.
module lt_int_serial_slice #(
   parameter int CHUNK     = 8,
   parameter int IMPL_TYPE = 0
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             bin_i,
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
   output logic             nz_o,
`endif
   output logic             bo_o
);

   generate
      if (IMPL_TYPE == 0) begin : g_arith
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
         logic [CHUNK:0] diff;
         // Full-width subtract; the MSB of the result is the borrow out.
         always_comb begin
            diff = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK{1'b0}}, bin_i};
            bo_o = diff[CHUNK];
            nz_o = |diff[CHUNK-1:0];
         end
`else
         // Without the equality flag only the borrow is needed:
         // a - b - bin underflows exactly when a < b + bin.
         always_comb begin
            bo_o = ({1'b0, a_i} < ({1'b0, b_i} + {{CHUNK{1'b0}}, bin_i}));
         end
`endif
      end else begin : g_ripple
         logic [CHUNK:0] br;
         // Bitwise ripple-borrow chain, LSB first.
         always_comb begin
            br    = '0;
            br[0] = bin_i;
            for (int i = 0; i < CHUNK; i++) begin
               br[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & br[i]);
            end
            bo_o = br[CHUNK];
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
            nz_o = |(a_i ^ b_i ^ br[CHUNK-1:0]);
`endif
         end
      end
   endgenerate

endmodule

// Top-level sequencer: IDLE -> RUN (NCHUNK cycles) -> DONE -> IDLE.
module lt_int_serial_ctrl #(
   parameter int WIDTH     = 32,
   parameter int CHUNK     = 8,
   parameter int IMPL_TYPE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             Y,
   output logic             busy
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
   ,
   output logic             EQ
`endif
);

   localparam int NCHUNK = WIDTH / CHUNK;
   // One extra bit so the counter reaches NCHUNK without wrapping.
   localparam int CW     = $clog2(NCHUNK) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   generate
      if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("lt_int_serial_ctrl: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sa_q, sa_d;   // captured sign of A
   logic             sb_q, sb_d;   // captured sign of B
   logic             brw_q, brw_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             y_q, y_d;
   logic             bo;
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
   logic             nz_q, nz_d;
   logic             eq_q, eq_d;
   logic             chunk_nz;
`endif

   lt_int_serial_slice #(
      .CHUNK     (CHUNK),
      .IMPL_TYPE (IMPL_TYPE)
   ) u_slice (
      .a_i   (a_q[CHUNK-1:0]),
      .b_i   (b_q[CHUNK-1:0]),
      .bin_i (brw_q),
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
      .nz_o  (chunk_nz),
`endif
      .bo_o  (bo)
   );

   // Next-state logic for the FSM and the chunk datapath.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
      nz_d    = nz_q;
      eq_d    = eq_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_RUN;
               a_d     = A;
               b_d     = B;
               sa_d    = A[WIDTH-1];
               sb_d    = B[WIDTH-1];
               brw_d   = 1'b0;
               cnt_d   = '0;
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
               nz_d    = 1'b0;
`endif
            end
         end
         S_RUN: begin
            brw_d = bo;
            a_d   = a_q >> CHUNK;
            b_d   = b_q >> CHUNK;
            cnt_d = cnt_q + 1'b1;
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
            nz_d  = nz_q | chunk_nz;
`endif
            if (cnt_q == CNT_LAST) begin
               // Unsigned borrow corrected by the operand signs gives
               // the signed less-than result.
               y_d     = bo ^ sa_q ^ sb_q;
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
               eq_d    = ~(nz_q | chunk_nz);
`endif
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, asynchronously cleared on rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         y_q     <= 1'b0;
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
         nz_q    <= 1'b0;
         eq_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
         nz_q    <= nz_d;
         eq_q    <= eq_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign Y         = y_q;
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
   assign EQ        = eq_q;
`endif

endmodule

// File: tb/tb_lt_int_serial_ctrl.sv
// Self-checking bench for lt_int_serial_ctrl: a driver pushes expected
// results (signed A < B) into a scoreboard, a monitor pops and compares
// whenever a result is handed off, and also checks the result latency.
module tb_lt_int_serial_ctrl;

   localparam int W = 32;
   localparam int N = 4;   // WIDTH / CHUNK

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic         Y;
   logic         busy;
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
   logic         EQ;
`endif

   lt_int_serial_ctrl #(.WIDTH(32), .CHUNK(8), .IMPL_TYPE(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Y         (Y),
      .busy      (busy)
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
      ,
      .EQ        (EQ)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           acc;
   } op_t;

   op_t sb_q[$];
   int  n_chk  = 0;
   int  n_fail = 0;
   int  cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: samples after the driver's update in each negative phase, so
   // out_valid && out_ready here means the handoff occurs at the next edge.
   initial begin
      logic prev_ov;
      op_t  e;
      prev_ov = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_ov = 1'b0;
         end else begin
            if (out_valid && !prev_ov) begin
               if (sb_q.size() == 0) chk("unexpected out_valid", 32'(out_valid), 0);
               else chk("latency", 32'(cyc - sb_q[0].acc), N);
            end
            if (out_valid && out_ready && sb_q.size() > 0) begin
               e = sb_q.pop_front();
               chk($sformatf("Y a=%0h b=%0h", e.a, e.b), 32'(Y),
                   32'($signed(e.a) < $signed(e.b)));
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
               chk($sformatf("EQ a=%0h b=%0h", e.a, e.b), 32'(EQ), 32'(e.a == e.b));
`endif
            end
            prev_ov = out_valid;
         end
      end
   end

   // Issue one operation; called in the negedge+1 phase.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      int t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk); #1; t++;
      end
      if (!in_ready) begin
         chk("in_ready timeout", 32'(in_ready), 1);
         return;
      end
      in_valid = 1'b1;
      A = a;
      B = b;
      sb_q.push_back('{a, b, cyc + 1});
      @(negedge clk); #1;
      in_valid = 1'b0;
      A = $urandom;
      B = $urandom;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((sb_q.size() != 0 || !in_ready) && t < 500) begin
         @(negedge clk); #1; t++;
      end
      if (t >= 500) chk("drain timeout", 32'(sb_q.size()), 0);
   endtask

   task automatic idle_check(input string nm);
      chk({nm, " in_ready"}, 32'(in_ready), 1);
      chk({nm, " out_valid"}, 32'(out_valid), 0);
      chk({nm, " busy"}, 32'(busy), 0);
      chk({nm, " Y"}, 32'(Y), 0);
`ifdef LT_INT_SERIAL_EQ_FLAG_EN
      chk({nm, " EQ"}, 32'(EQ), 0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb;
      int           t;
      logic         y0;

      repeat (2) @(negedge clk);
      #1 rst = 1'b0;

      // Reset then idle for 5 cycles.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         idle_check("idle");
      end

      // Directed values and boundaries.
      issue(-32'sd5, 32'sd3);
      wait_idle();
      issue(32'sd3, -32'sd5);
      issue(32'h8000_0000, 32'h7FFF_FFFF);
      issue(32'h7FFF_FFFF, 32'h8000_0000);
      issue(32'h1234_5678, 32'h1234_5678);
      issue(32'h0000_0100, 32'h0000_01FF);
      issue(32'h0000_01FF, 32'h0000_0100);
      issue(32'hFFFF_FFFF, 32'h0000_0000);
      wait_idle();

      // Randomized operands, biased toward near-equal pairs.
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = ra ^ 32'($urandom_range(1, 255));
            1: rb = ra;
            2: rb = ra + 32'($urandom_range(0, 3)) - 32'd1;
            default: rb = $urandom;
         endcase
         issue(ra, rb);
      end
      wait_idle();

      // Backpressure: result held, new in_valid ignored.
      out_ready = 1'b0;
      issue(-32'sd7, 32'sd9);
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk); #1; t++;
      end
      chk("bp out_valid rise", 32'(out_valid), 1);
      y0 = Y;
      chk("bp Y value", 32'(y0), 1);
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         A = 32'd1;
         B = 32'd0;
         @(negedge clk); #1;
         chk("bp out_valid held", 32'(out_valid), 1);
         chk("bp Y held", 32'(Y), 32'(y0));
         chk("bp in_ready low", 32'(in_ready), 0);
         chk("bp busy", 32'(busy), 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk); #1;
      chk("bp release in_ready", 32'(in_ready), 1);
      chk("bp release out_valid", 32'(out_valid), 0);
      chk("bp release busy", 32'(busy), 0);
      chk("bp release Y kept", 32'(Y), 1);
      wait_idle();

      // Reset asserted in the 2nd RUN cycle aborts the operation.
      in_valid = 1'b1;
      A = 32'd7;
      B = 32'd3;
      @(negedge clk); #1;
      in_valid = 1'b0;
      chk("abort accepted busy", 32'(busy), 1);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      idle_check("async reset");
      @(negedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
      end
      chk("after abort out_valid", 32'(out_valid), 0);
      issue(32'd1, 32'd2);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
